// File: rtl/periph_pkg.sv
// Shared constants for the peripheral responder: register offsets, TCON bit
// positions and the UART transmitter state encoding.
package periph_pkg;

    localparam logic [4:0] OFS_TH    = 5'h00;
    localparam logic [4:0] OFS_TL    = 5'h04;
    localparam logic [4:0] OFS_TCON  = 5'h08;
    localparam logic [4:0] OFS_LED   = 5'h0C;
    localparam logic [4:0] OFS_UTXD  = 5'h18;
    localparam logic [4:0] OFS_USTAT = 5'h1C;

    localparam int TCON_RUN = 0;
    localparam int TCON_IEN = 1;
    localparam int TCON_IRQ = 2;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_engine.sv
// 8N1 serial transmitter, LSB first. A start request is honoured only in IDLE;
// the line output is registered so it changes exactly on clock edges.
module uart_tx_engine
    import periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iStart,
    input  logic [7:0] iData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oTx,
    output logic [1:0] oState
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic             done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done    = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != UART_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            UART_IDLE: begin
                if (iStart) begin
                    shift_d = iData;
                    cnt_d   = '0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    state_d = UART_DATA;
                end
            end
            UART_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = UART_STOP;
                    end
                end
            end
            UART_STOP: begin
                if (bit_end) begin
                    done    = 1'b1;
                    state_d = UART_IDLE;
                end
            end
            default: state_d = UART_IDLE;
        endcase

        // Line level is derived from the next state so it lands on the same edge as the state.
        case (state_d)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase
    end

    assign oBusy  = (state_q != UART_IDLE);
    assign oDone  = done;
    assign oTx    = tx_q;
    assign oState = state_q;

endmodule

// File: rtl/periph_bus_responder.sv
// Memory-mapped peripheral block on the core's data port: reload timer with
// interrupt, LED latch and a UART transmitter with sticky completion flag.
module periph_bus_responder
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int          CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iMemAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oInterrupt,
    output logic [7:0]  oLed,
    output logic        oUartTx
);

    logic        hit;
    logic [4:0]  ofs;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_utxd, rd_ustat;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic        txdone_q, txdone_d;
    logic        tl_ovf, irq_set;

    logic        uart_start, uart_busy, uart_done;
    logic [1:0]  uart_state;

    assign hit = (iMemAddr[31:5] == BASE_ADDR[31:5]);
    assign ofs = iMemAddr[4:0] & 5'b11100;

    assign wr_th    = iMemWrite && hit && (ofs == OFS_TH);
    assign wr_tl    = iMemWrite && hit && (ofs == OFS_TL);
    assign wr_tcon  = iMemWrite && hit && (ofs == OFS_TCON);
    assign wr_led   = iMemWrite && hit && (ofs == OFS_LED);
    assign wr_utxd  = iMemWrite && hit && (ofs == OFS_UTXD);
    // A simultaneous read+write is a write, so it must not clear txdone.
    assign rd_ustat = iMemRead && !iMemWrite && hit && (ofs == OFS_USTAT);

    assign uart_start = wr_utxd && (uart_state == UART_IDLE);

    uart_tx_engine #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk    (clk),
        .reset  (reset),
        .iStart (uart_start),
        .iData  (iMemWriteData[7:0]),
        .oBusy  (uart_busy),
        .oDone  (uart_done),
        .oTx    (oUartTx),
        .oState (uart_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q     <= '0;
            tl_q     <= '0;
            tcon_q   <= '0;
            led_q    <= '0;
            txdone_q <= 1'b0;
        end else begin
            th_q     <= th_d;
            tl_q     <= tl_d;
            tcon_q   <= tcon_d;
            led_q    <= led_d;
            txdone_q <= txdone_d;
        end
    end

    always_comb begin
        th_d     = th_q;
        tl_d     = tl_q;
        tcon_d   = tcon_q;
        led_d    = led_q;
        txdone_d = txdone_q;
        tl_ovf   = tcon_q[TCON_RUN] && (tl_q == 32'hFFFF_FFFF);
        irq_set  = tl_ovf && tcon_q[TCON_IEN];

        if (tcon_q[TCON_RUN]) begin
            tl_d = tl_ovf ? th_q : tl_q + 32'd1;
        end
        if (irq_set) begin
            tcon_d[TCON_IRQ] = 1'b1;
        end

        // Bus writes take priority over the timer, except that a hardware IRQ set survives.
        if (wr_th) begin
            th_d = iMemWriteData;
        end
        if (wr_tl) begin
            tl_d = iMemWriteData;
        end
        if (wr_tcon) begin
            tcon_d           = iMemWriteData[2:0];
            tcon_d[TCON_IRQ] = iMemWriteData[TCON_IRQ] | irq_set;
        end
        if (wr_led) begin
            led_d = iMemWriteData[7:0];
        end

        if (rd_ustat) begin
            txdone_d = 1'b0;
        end
        if (uart_done) begin
            txdone_d = 1'b1;
        end
    end

    always_comb begin
        oMemReadData = '0;
        if (hit) begin
            case (ofs)
                OFS_TH:    oMemReadData = th_q;
                OFS_TL:    oMemReadData = tl_q;
                OFS_TCON:  oMemReadData = {29'd0, tcon_q};
                OFS_LED:   oMemReadData = {24'd0, led_q};
                OFS_USTAT: oMemReadData = {30'd0, txdone_q, uart_busy};
                default:   oMemReadData = '0;
            endcase
        end
    end

    assign oInterrupt = tcon_q[TCON_IRQ];
    assign oLed       = led_q;

endmodule

// File: tb/tb_periph_bus_responder.sv
// Bench for periph_bus_responder: directed register/timer/UART scenarios followed
// by random bus traffic, all checked against a register-level reference model.
module tb_periph_bus_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          CPB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  led;
    logic        uart_tx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [0:0]  tx_q[$];

    logic [31:0] m_th = '0;
    logic [31:0] m_tl = '0;
    logic [2:0]  m_tcon = '0;
    logic [7:0]  m_led = '0;
    logic        m_txdone = 1'b0;
    int          m_left = 0;

    periph_bus_responder #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .iMemAddr      (mem_addr),
        .iMemRead      (mem_rd),
        .iMemWrite     (mem_wr),
        .iMemWriteData (mem_wdata),
        .oMemReadData  (rdata),
        .oInterrupt    (irq),
        .oLed          (led),
        .oUartTx       (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file semantics evaluated once per clock edge.
    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr[31:5] != BASE[31:5]) return 32'h0;
        case (addr[4:2])
            3'd0:    return m_th;
            3'd1:    return m_tl;
            3'd2:    return {29'd0, m_tcon};
            3'd3:    return {24'd0, m_led};
            3'd7:    return {30'd0, m_txdone, (m_left != 0)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic        hit, wr, rdc, ovf, irq_set, done_now, was_busy;
        logic [2:0]  w;
        logic [31:0] tl_n;
        logic [2:0]  tcon_n;
        logic [0:0]  lvl;
        if (rst) begin
            m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0;
            m_txdone = 1'b0; m_left = 0;
            tx_q.delete();
            return;
        end
        hit     = (mem_addr[31:5] == BASE[31:5]);
        w       = mem_addr[4:2];
        wr      = mem_wr && hit;
        rdc     = mem_rd && !mem_wr && hit && (w == 3'd7);
        ovf     = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        irq_set = ovf && m_tcon[1];
        tl_n    = m_tcon[0] ? (ovf ? m_th : m_tl + 32'd1) : m_tl;
        tcon_n  = m_tcon | {irq_set, 2'b00};
        was_busy = (m_left != 0);
        done_now = (m_left == 1);
        if (m_left > 0) m_left--;
        if (wr) begin
            case (w)
                3'd0: m_th = mem_wdata;
                3'd1: tl_n = mem_wdata;
                3'd2: tcon_n = {mem_wdata[2] | irq_set, mem_wdata[1:0]};
                3'd3: m_led = mem_wdata[7:0];
                3'd6: if (!was_busy) begin
                    m_left = 10 * CPB;
                    for (int b = 0; b < 10; b++) begin
                        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mem_wdata[b-1];
                        for (int k = 0; k < CPB; k++) tx_q.push_back(lvl);
                    end
                end
                default: ;
            endcase
        end
        m_tl   = tl_n;
        m_tcon = tcon_n;
        if (rdc) m_txdone = 1'b0;
        if (done_now) m_txdone = 1'b1;
    endtask

    always @(posedge clk) model_step();

    // Monitor: compares every DUT output at the falling edge.
    always @(negedge clk) begin : monitor
        logic [0:0] t;
        if (mem_rd) begin
            if (exp_q.size() == 0) check("rdata_unexpected", rdata, 32'hDEAD_BEEF);
            else check("rdata", rdata, exp_q.pop_front());
        end
        t = (tx_q.size() != 0) ? tx_q.pop_front() : 1'b1;
        check("uart_tx", {31'd0, uart_tx}, {31'd0, t});
        check("led", {24'd0, led}, {24'd0, m_led});
        check("irq", {31'd0, irq}, {31'd0, m_tcon[2]});
    end

    // Driver tasks: each occupies one clock cycle; writes commit at the closing edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic use_const, input logic [31:0] cexp);
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = data;
        if (rd) exp_q.push_back(use_const ? cexp : model_read(addr));
    endtask

    task automatic idle();
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] ofs, input logic [31:0] data);
        access(1'b0, 1'b1, BASE | {27'd0, ofs}, data, 1'b0, 32'h0);
    endtask

    task automatic rd_const(input logic [31:0] addr, input logic [31:0] exp);
        access(1'b1, 1'b0, addr, 32'h0, 1'b1, exp);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        int r;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        rd_const(BASE + 32'h08, 32'h0);
        rd_const(BASE + 32'h00, 32'h0);
        rd_const(BASE + 32'h04, 32'h0);
        rd_const(BASE + 32'h1C, 32'h0);

        // Timer reload and interrupt
        wr_reg(5'h00, 32'hFFFF_FFF0);
        wr_reg(5'h04, 32'hFFFF_FFFE);
        wr_reg(5'h08, 32'h3);
        idle();
        rd_const(BASE + 32'h04, 32'hFFFF_FFFF);
        rd_const(BASE + 32'h04, 32'hFFFF_FFF0);
        @(negedge clk);
        check("irq_set", {31'd0, irq}, 32'd1);
        wr_reg(5'h08, 32'h3);
        idle();
        @(negedge clk);
        check("irq_clear", {31'd0, irq}, 32'd0);

        // Overflow coincident with TCON write; TL write overrides increment
        wr_reg(5'h08, 32'h0);
        wr_reg(5'h00, 32'h0);
        wr_reg(5'h04, 32'hFFFF_FFFE);
        wr_reg(5'h08, 32'h3);
        idle();
        wr_reg(5'h08, 32'h3);
        rd_const(BASE + 32'h08, 32'h7);
        wr_reg(5'h08, 32'h1);
        wr_reg(5'h04, 32'h5);
        rd_const(BASE + 32'h04, 32'h5);
        wr_reg(5'h08, 32'h0);

        // UART frame A5, busy window and txdone read-clear (set wins on coincident edge)
        wr_reg(5'h18, 32'hA5);
        rd_const(BASE + 32'h1C, 32'h1);
        repeat (38) idle();
        rd_const(BASE + 32'h1C, 32'h1);
        rd_const(BASE + 32'h1C, 32'h2);
        rd_const(BASE + 32'h1C, 32'h0);

        // Write while busy is dropped
        wr_reg(5'h18, 32'hA5);
        repeat (5) idle();
        wr_reg(5'h18, 32'h3C);
        repeat (45) idle();
        rd_const(BASE + 32'h1C, 32'h2);

        // Reset mid-DATA abandons the frame
        wr_reg(5'h18, 32'hFF);
        repeat (10) idle();
        pulse_reset();
        @(negedge clk);
        check("midreset_tx", {31'd0, uart_tx}, 32'd1);
        rd_const(BASE + 32'h1C, 32'h0);

        // Miss addresses and LED width
        rd_const(32'h4000_0020, 32'h0);
        rd_const(32'h5000_0000, 32'h0);
        wr_reg(5'h0C, 32'h1FF);
        idle();
        @(negedge clk);
        check("led_trunc", {24'd0, led}, 32'hFF);
        rd_const(BASE + 32'h0C, 32'hFF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            a = BASE | {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a = a ^ (32'h1 << $urandom_range(5, 31));
            d = $urandom;
            if (a[4:2] == 3'd1 || a[4:2] == 3'd0) begin
                if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | {28'd0, 4'($urandom_range(0, 15))};
            end
            if (r == 9) idle();
            else access(r < 5, r >= 4, a, d, 1'b0, 32'h0);
        end
        repeat (60) idle();

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
